store_merge_buffer: RTL and testbench
=====================================

STORE_MERGE_BUFFER -- requirements
Module: store_merge_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory word width (32 or 64); NB = DATA_W/8 byte lanes.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 4, number of buffer entries (power of two, >=2).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 st_valid  in  1  store request present.
REQ-008 st_ready  out  1  store accepted this cycle when high with st_valid.
REQ-009 st_addr  in  ADDR_W  store byte address.
REQ-010 st_size  in  2  00 byte, 01 half, 10 word, 11 dword.
REQ-011 st_data  in  DATA_W  store data, right-justified.
REQ-012 mem_valid  out  1  head entry offered to memory.
REQ-013 mem_ready  in  1  memory accepts head entry.
REQ-014 mem_addr  out  ADDR_W  head word address; low log2(NB) bits zero.
REQ-015 mem_wdata  out  DATA_W  head merged data; unenabled lanes zero.
REQ-016 mem_be  out  NB  head byte enables.
REQ-017 misalign_err  out  1  one-cycle pulse on a rejected store.
REQ-018 count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-019 Alignment: size s covers 2^s bytes at lane st_addr[log2(NB)-1:0]; data lanes = st_data low bytes shifted to that lane; be set for covered lanes only.
REQ-020 Half at odd address, word not 4-aligned, dword not 8-aligned, or dword with DATA_W=32 SHALL be misaligned.
REQ-021 Misaligned store with st_valid SHALL assert st_ready, allocate nothing, and pulse misalign_err the following cycle.
REQ-022 st_ready SHALL be !full, or 1 on a coalesce hit (REQ-032) or misaligned store.
REQ-023 An accepted aligned store SHALL write the tail entry {word addr, lanes, be} and increment count at that edge.
REQ-024 mem_valid SHALL equal (count != 0); outputs SHALL be driven from head entry registers, no combinational path from st_* inputs.
REQ-025 Latency: a store accepted into an empty buffer at edge N SHALL give mem_valid high after edge N.
REQ-026 Head pops on mem_valid && mem_ready; mem_* SHALL hold stable while mem_valid && !mem_ready.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; with count == DEPTH, push SHALL NOT occur in the same cycle as pop (st_ready uses registered full).
REQ-028 Pointers SHALL wrap modulo DEPTH; order of drain SHALL equal order of acceptance.
REQ-029 count SHALL never exceed DEPTH nor underflow; mem_ready with count == 0 SHALL have no effect.

Reset
REQ-030 On reset: count 0, head/tail pointers 0, mem_valid 0, misalign_err 0, all entry be cleared; mem_addr/mem_wdata 0.
REQ-031 Reset asserted mid-drain SHALL discard all entries immediately; no partial store SHALL be presented after reset release.

Configuration
REQ-032 Macro STORE_MERGE_COALESCE_EN defined: an aligned store whose word address equals the youngest entry's, where that entry is not popped this cycle, SHALL merge into it (new lanes overwrite, be OR'd), count unchanged, accepted even when full.
REQ-033 Without STORE_MERGE_COALESCE_EN every aligned accepted store SHALL allocate a new entry.

Structure
REQ-034 Package store_merge_pkg SHALL hold the st_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD) and the entry struct type.
REQ-035 Sub-module store_lane_align SHALL be combinational: addr, size, data -> lanes, be, misaligned; instantiated once.

Verification
REQ-036 DATA_W=32: sb addr 0x1003 data 0xAB -> mem_addr 0x1000, mem_be 4'b1000, mem_wdata 0xAB000000.
REQ-037 sh addr 0x2001 -> misalign_err pulse one cycle, count stays 0, mem_valid stays 0.
REQ-038 DEPTH=4, mem_ready=0, four sw to distinct words -> count 4, st_ready 0; mem_ready=1 -> drain in order, one per cycle.
REQ-039 COALESCE_EN: sb 0x10 data 0x11 then sb 0x12 data 0x22, mem_ready=0 -> count 1, be 4'b0101, wdata 0x00220011; macro off -> count 2.
REQ-040 DATA_W=64: sd addr 0x8 data 0x0123456789ABCDEF -> be 8'hFF, wdata same; sd addr 0x4 -> misalign_err.
REQ-041 Reset asserted with count 3 -> next cycle count 0, mem_valid 0; fresh store drains correctly.

Source files
------------

// File: rtl/store_merge_pkg.sv
// Shared types for the store merge buffer: store size encodings and the buffer entry layout.
// Entries are sized for the widest configuration; narrower builds leave the upper bits zero.
package store_merge_pkg;

  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_ADDR_W = 64;
  localparam int unsigned MAX_NB     = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } st_size_e;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
    logic [MAX_NB-1:0]     be;
  } entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational store aligner: places right-justified store data on its byte lanes,
// builds the byte enables and flags misaligned accesses.
module store_lane_align import store_merge_pkg::*; #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [OFF_W-1:0]    addr,
  input  st_size_e            size,
  input  logic [DATA_W-1:0]   data,
  output logic [DATA_W-1:0]   lanes,
  output logic [DATA_W/8-1:0] be,
  output logic                misaligned
);

  localparam int unsigned NB = DATA_W / 8;

  logic [7:0]        off;
  logic [7:0]        size_mask;
  logic [DATA_W-1:0] keep;

  always_comb begin
    off        = 8'(addr);
    size_mask  = 8'hFF;
    misaligned = 1'b0;
    keep       = '0;
    case (size)
      SZ_BYTE: size_mask = 8'h01;
      SZ_HALF: begin
        size_mask  = 8'h03;
        misaligned = off[0];
      end
      SZ_WORD: begin
        size_mask  = 8'h0F;
        misaligned = (off[1:0] != 2'b00);
      end
      default: begin
        size_mask  = 8'hFF;
        // A doubleword can never fit a 32-bit memory word.
        misaligned = (NB < 8) || (off[2:0] != 3'b000);
      end
    endcase
    for (int unsigned i = 0; i < NB; i++) begin
      keep[i*8 +: 8] = {8{size_mask[i]}};
    end
    lanes = (data & keep) << {off, 3'b000};
    be    = NB'({8'h00, size_mask} << off);
  end

endmodule

// File: rtl/store_merge_buffer.sv
// In-order store buffer that aligns stores to memory words and drains them one per cycle.
// Define STORE_MERGE_COALESCE_EN to merge a store into the youngest entry of the same word.
module store_merge_buffer import store_merge_pkg::*; #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [1:0]               st_size,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [DATA_W/8-1:0]      mem_be,
  output logic                     misalign_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t            entries_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q, young_idx, wr_idx;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              misalign_err_q;

  logic [DATA_W-1:0]     st_lanes, st_mask;
  logic [NB-1:0]         st_be;
  logic                  st_misaligned;
  logic [MAX_ADDR_W-1:0] st_word_addr;
  logic                  full, empty, pop, push, hit, wr_en;
  entry_t                young_e, wr_entry, head_e;
  logic                  unused_head;

  store_lane_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .addr       (st_addr[OFF_W-1:0]),
    .size       (st_size_e'(st_size)),
    .data       (st_data),
    .lanes      (st_lanes),
    .be         (st_be),
    .misaligned (st_misaligned)
  );

  assign st_word_addr = MAX_ADDR_W'({st_addr[ADDR_W-1:OFF_W], OFF_W'(0)});
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign pop          = !empty && mem_ready;
  assign young_idx    = tail_q - PTR_W'(1);
  assign young_e      = entries_q[young_idx];

`ifdef STORE_MERGE_COALESCE_EN
  // A youngest entry leaving this cycle can no longer absorb the store.
  assign hit = st_valid && !st_misaligned && !empty && (young_e.addr == st_word_addr) &&
               !(pop && (count_q == CNT_W'(1)));
`else
  assign hit = 1'b0;
`endif

  // Full is taken from the registered count, so a pop never frees a slot in the same cycle.
  assign st_ready = !full || hit || st_misaligned;
  assign push     = st_valid && st_ready && !st_misaligned && !hit;
  assign wr_en    = push || hit;
  assign wr_idx   = hit ? young_idx : tail_q;

  always_comb begin
    st_mask = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      st_mask[i*8 +: 8] = {8{st_be[i]}};
    end
    wr_entry = '0;
    if (hit) begin
      wr_entry.addr = young_e.addr;
      wr_entry.data = (young_e.data & ~MAX_DATA_W'(st_mask)) | MAX_DATA_W'(st_lanes);
      wr_entry.be   = young_e.be | MAX_NB'(st_be);
    end else begin
      wr_entry.addr = st_word_addr;
      wr_entry.data = MAX_DATA_W'(st_lanes);
      wr_entry.be   = MAX_NB'(st_be);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      if (wr_en) begin
        entries_q[wr_idx] <= wr_entry;
      end
      if (push) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      count_q        <= count_d;
      misalign_err_q <= st_valid && st_misaligned;
    end
  end

  assign head_e       = entries_q[head_q];
  assign mem_valid    = !empty;
  assign mem_addr     = head_e.addr[ADDR_W-1:0];
  assign mem_wdata    = head_e.data[DATA_W-1:0];
  assign mem_be       = head_e.be[NB-1:0];
  assign misalign_err = misalign_err_q;
  assign count        = count_q;
  assign unused_head  = ^head_e;

endmodule

// File: tb/tb_store_merge_buffer.sv
// Directed bench for store_merge_buffer: a 32-bit and a 64-bit instance, depth 4.
// Expected coalescing results follow STORE_MERGE_COALESCE_EN as seen by this bench.
module tb_store_merge_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, st_ready, mem_valid, mem_ready, misalign_err;
  logic [31:0] st_addr, st_data, mem_addr, mem_wdata;
  logic [1:0]  st_size;
  logic [3:0]  mem_be;
  logic [2:0]  count;

  logic        b_st_valid, b_st_ready, b_mem_valid, b_mem_ready, b_misalign_err;
  logic [31:0] b_st_addr, b_mem_addr;
  logic [63:0] b_st_data, b_mem_wdata;
  logic [1:0]  b_st_size;
  logic [7:0]  b_mem_be;
  logic [2:0]  b_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_merge_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_size      (st_size),
    .st_data      (st_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .misalign_err (misalign_err),
    .count        (count)
  );

  store_merge_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .st_valid     (b_st_valid),
    .st_ready     (b_st_ready),
    .st_addr      (b_st_addr),
    .st_size      (b_st_size),
    .st_data      (b_st_data),
    .mem_valid    (b_mem_valid),
    .mem_ready    (b_mem_ready),
    .mem_addr     (b_mem_addr),
    .mem_wdata    (b_mem_wdata),
    .mem_be       (b_mem_be),
    .misalign_err (b_misalign_err),
    .count        (b_count)
  );

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one store for a single clock edge; returns 1 time unit after that edge.
  task automatic st_a(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    @(negedge clk);
    st_valid = 1'b1;
    st_addr  = a;
    st_size  = s;
    st_data  = d;
    @(posedge clk);
    #1 st_valid = 1'b0;
  endtask

  task automatic st_b(input logic [31:0] a, input logic [1:0] s, input logic [63:0] d);
    @(negedge clk);
    b_st_valid = 1'b1;
    b_st_addr  = a;
    b_st_size  = s;
    b_st_data  = d;
    @(posedge clk);
    #1 b_st_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    st_valid    = 1'b0;
    st_addr     = '0;
    st_size     = '0;
    st_data     = '0;
    mem_ready   = 1'b0;
    b_st_valid  = 1'b0;
    b_st_addr   = '0;
    b_st_size   = '0;
    b_st_data   = '0;
    b_mem_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_misalign", misalign_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_b_count", b_count, 0);
    reset = 1'b0;

    // Byte store to the top lane
    st_a(32'h1003, 2'b00, 32'h0000_00AB);
    chk("sb_mem_valid", mem_valid, 1);
    chk("sb_count", count, 1);
    chk("sb_mem_addr", mem_addr, 32'h1000);
    chk("sb_mem_be", mem_be, 4'b1000);
    chk("sb_mem_wdata", mem_wdata, 32'hAB00_0000);
    @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    chk("sb_pop_count", count, 0);
    chk("sb_pop_valid", mem_valid, 0);

    // Aligned halfword on the upper half
    st_a(32'h0002, 2'b01, 32'h0000_BEEF);
    chk("sh_mem_be", mem_be, 4'b1100);
    chk("sh_mem_wdata", mem_wdata, 32'hBEEF_0000);
    @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    chk("sh_pop_count", count, 0);

    // Misaligned halfword
    @(negedge clk);
    st_valid = 1'b1;
    st_addr  = 32'h2001;
    st_size  = 2'b01;
    st_data  = 32'h0000_1234;
    #1 chk("mis_st_ready", st_ready, 1);
    @(posedge clk);
    #1 st_valid = 1'b0;
    chk("mis_pulse", misalign_err, 1);
    chk("mis_count", count, 0);
    chk("mis_mem_valid", mem_valid, 0);
    @(posedge clk);
    #1 chk("mis_pulse_end", misalign_err, 0);

    // Doubleword is always misaligned on a 32-bit memory
    st_a(32'h0000, 2'b11, 32'h1111_2222);
    chk("sd32_misalign", misalign_err, 1);
    chk("sd32_count", count, 0);

    // Fill to depth, then drain in order
    for (int i = 0; i < 4; i++) begin
      st_a(32'h100 + 32'(i * 4), 2'b10, 32'hA000_0000 + 32'(i));
    end
    chk("full_count", count, 4);
    @(negedge clk);
    st_valid  = 1'b1;
    st_addr   = 32'h200;
    st_size   = 2'b10;
    st_data   = 32'hDEAD_BEEF;
    #1 chk("full_st_ready", st_ready, 0);
    @(posedge clk);
    #1 chk("full_no_push", count, 4);
    @(negedge clk);
    mem_ready = 1'b1;
    #1 chk("full_pop_st_ready", st_ready, 0);
    st_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_addr", mem_addr, 32'h100 + 32'(i * 4));
      chk("drain_wdata", mem_wdata, 32'hA000_0000 + 32'(i));
      chk("drain_valid", mem_valid, 1);
      @(negedge clk);
    end
    chk("drain_count", count, 0);
    chk("drain_valid_end", mem_valid, 0);
    @(negedge clk);
    chk("empty_ready_count", count, 0);

    // Simultaneous push and pop
    st_a(32'h300, 2'b10, 32'h3333_3333);
    chk("pp_first_count", count, 1);
    st_a(32'h304, 2'b10, 32'h4444_4444);
    chk("pp_count", count, 1);
    chk("pp_head_addr", mem_addr, 32'h304);
    chk("pp_head_wdata", mem_wdata, 32'h4444_4444);
    @(posedge clk);
    #1 chk("pp_drained", count, 0);
    mem_ready = 1'b0;

    // Two bytes to one word
    st_a(32'h10, 2'b00, 32'h0000_0011);
    st_a(32'h12, 2'b00, 32'h0000_0022);
`ifdef STORE_MERGE_COALESCE_EN
    chk("merge_count", count, 1);
    chk("merge_be", mem_be, 4'b0101);
    chk("merge_wdata", mem_wdata, 32'h0022_0011);
`else
    chk("merge_count", count, 2);
    chk("merge_be", mem_be, 4'b0001);
    chk("merge_wdata", mem_wdata, 32'h0000_0011);
`endif
    chk("merge_addr", mem_addr, 32'h10);
    @(negedge clk);
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_ready = 1'b0;
    chk("merge_drained", count, 0);

    // Reset mid-drain
    st_a(32'h400, 2'b10, 32'h0400_0400);
    st_a(32'h404, 2'b10, 32'h0404_0404);
    st_a(32'h408, 2'b10, 32'h0408_0408);
    chk("pre_rst_count", count, 3);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", mem_valid, 0);
    chk("mid_rst_be", mem_be, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", mem_valid, 0);
    st_a(32'h500, 2'b10, 32'hCAFE_F00D);
    chk("post_rst_count", count, 1);
    chk("post_rst_addr", mem_addr, 32'h500);
    chk("post_rst_be", mem_be, 4'b1111);
    chk("post_rst_wdata", mem_wdata, 32'hCAFE_F00D);
    @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    chk("post_rst_drained", count, 0);

    // 64-bit memory: aligned and misaligned doublewords
    st_b(32'h8, 2'b11, 64'h0123_4567_89AB_CDEF);
    chk("sd64_count", b_count, 1);
    chk("sd64_addr", b_mem_addr, 32'h8);
    chk("sd64_be", b_mem_be, 8'hFF);
    chk("sd64_wdata", b_mem_wdata, 64'h0123_4567_89AB_CDEF);
    st_b(32'h4, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sd64_misalign", b_misalign_err, 1);
    chk("sd64_mis_count", b_count, 1);
    st_b(32'h4, 2'b10, 64'h0000_0000_5566_7788);
    chk("sw64_count", b_count, 2);
    @(negedge clk);
    b_mem_ready = 1'b1;
    @(posedge clk);
    #1 chk("sw64_head_addr", b_mem_addr, 32'h0);
    chk("sw64_head_be", b_mem_be, 8'hF0);
    chk("sw64_head_wdata", b_mem_wdata, 64'h5566_7788_0000_0000);
    b_mem_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
